// File: rtl/univ_shift_reg_if.sv
// Bus bundle for the universal shift register: control, serial/parallel data in,
// register contents, serial ends and fill status out.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic             clr;
    logic [1:0]       mode;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] pdata;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    count;
    logic             full;
    logic             done;

    modport master (
        output en, clr, mode, sin_l, sin_r, pdata,
        input  q, sout_l, sout_r, count, full, done
    );

    modport slave (
        input  en, clr, mode, sin_l, sin_r, pdata,
        output q, sout_l, sout_r, count, full, done
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold/shift-right/shift-left/load) with saturating fill count and done pulse.
// One-cycle latency for q/count/full/done; serial ends are combinational from q; no backpressure.
module univ_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    univ_shift_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [CW-1:0]    count_r;
    logic             done_r;

    logic [CW-1:0]    count_shift;
    logic             done_shift;

    // Shifting counts words, not bits beyond a word: saturate so full stays asserted.
    assign count_shift = (count_r == CNT_FULL) ? count_r : count_r + CW'(1);
    assign done_shift  = (count_r == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r     <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
        end else if (bus.clr) begin
            q_r     <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
        end else if (!bus.en) begin
            done_r  <= 1'b0;
        end else begin
            case (bus.mode)
                MODE_SHR: begin
                    q_r     <= {bus.sin_l, q_r[WIDTH-1:1]};
                    count_r <= count_shift;
                    done_r  <= done_shift;
                end
                MODE_SHL: begin
                    q_r     <= {q_r[WIDTH-2:0], bus.sin_r};
                    count_r <= count_shift;
                    done_r  <= done_shift;
                end
                MODE_LOAD: begin
                    q_r     <= bus.pdata;
                    count_r <= CNT_FULL;
                    done_r  <= 1'b0;
                end
                MODE_HOLD: begin
                    done_r  <= 1'b0;
                end
                default: begin
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q      = q_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
    assign bus.count  = count_r;
    assign bus.full   = (count_r == CNT_FULL);
    assign bus.done   = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8: vector table plus hand-written
// sequences for async reset and enable gating.
module tb_univ_shift_reg;
    localparam int WIDTH = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    univ_shift_reg_if #(.WIDTH(WIDTH)) bus ();

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       en;
        logic [1:0] mode;
        logic       sin_l;
        logic       sin_r;
        logic [7:0] pdata;
        logic [7:0] exp_q;
        logic [3:0] exp_cnt;
        logic       exp_full;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic en, logic [1:0] mode, logic sin_l,
                                logic sin_r, logic [7:0] pdata, logic [7:0] q,
                                logic [3:0] cnt, logic full, logic done);
        vec_t v;
        v.clr = clr;   v.en = en;       v.mode = mode;   v.sin_l = sin_l;
        v.sin_r = sin_r; v.pdata = pdata; v.exp_q = q;   v.exp_cnt = cnt;
        v.exp_full = full; v.exp_done = done;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [7:0] q, input logic [3:0] cnt,
                             input logic full, input logic done);
        check({tag, " q"},      32'(bus.q),      32'(q));
        check({tag, " count"},  32'(bus.count),  32'(cnt));
        check({tag, " full"},   32'(bus.full),   32'(full));
        check({tag, " done"},   32'(bus.done),   32'(done));
        check({tag, " sout_l"}, 32'(bus.sout_l), 32'(q[7]));
        check({tag, " sout_r"}, 32'(bus.sout_r), 32'(q[0]));
    endtask

    task automatic drive(input logic clr, input logic en, input logic [1:0] mode,
                         input logic sin_l, input logic sin_r, input logic [7:0] pdata);
        bus.clr = clr; bus.en = en; bus.mode = mode;
        bus.sin_l = sin_l; bus.sin_r = sin_r; bus.pdata = pdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_pulses;
        int done_at;
        logic [7:0] sr_bits;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);

        // Word-level behaviour: shift-left fill, saturation, clr priority, load+shift-right, rotate.
        vecs.push_back(mk(0,1,2'b10,0,1,8'h00, 8'h01,4'd1,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h02,4'd2,0,0));
        vecs.push_back(mk(0,1,2'b10,0,1,8'h00, 8'h05,4'd3,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h0A,4'd4,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h14,4'd5,0,0));
        vecs.push_back(mk(0,1,2'b10,0,1,8'h00, 8'h29,4'd6,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h52,4'd7,0,0));
        vecs.push_back(mk(0,1,2'b10,0,1,8'h00, 8'hA5,4'd8,1,1));
        vecs.push_back(mk(0,1,2'b10,0,0,8'h00, 8'h4A,4'd8,1,0));
        vecs.push_back(mk(1,1,2'b11,0,0,8'hFF, 8'h00,4'd0,0,0));
        vecs.push_back(mk(0,1,2'b11,0,0,8'hFF, 8'hFF,4'd8,1,0));
        vecs.push_back(mk(0,1,2'b11,0,0,8'h3C, 8'h3C,4'd8,1,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h9E,4'd8,1,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'hCF,4'd8,1,0));
        vecs.push_back(mk(0,1,2'b11,0,0,8'h81, 8'h81,4'd8,1,0));
        vecs.push_back(mk(0,1,2'b10,0,1,8'h00, 8'h03,4'd8,1,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h81,4'd8,1,0));
        vecs.push_back(mk(0,1,2'b00,0,1,8'h55, 8'h81,4'd8,1,0));
        vecs.push_back(mk(1,0,2'b00,0,0,8'h00, 8'h00,4'd0,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,8'h00, 8'h80,4'd1,0,0));

        step();
        step();
        check_all("reset state", 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].sin_l, vecs[i].sin_r, vecs[i].pdata);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt,
                      vecs[i].exp_full, vecs[i].exp_done);
        end

        // Async reset mid-word, then the first post-reset edge shifts normally.
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        step(); step(); step();
        check_all("pre-reset", 8'h07, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all("async reset", 8'h00, 4'd0, 1'b0, 1'b0);
        #1 reset = 1'b0;
        drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        step();
        check_all("post-reset shift", 8'h01, 4'd1, 1'b0, 1'b0);

        // Enable gating mid-word: hold for 4 cycles with mode=10, then finish the word.
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        step();
        sr_bits = 8'b1100_0000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b10, 1'b0, sr_bits[7-i], 8'h00);
            step();
        end
        check_all("pre-hold", 8'h06, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 8'h00);
            step();
            check_all($sformatf("en hold %0d", i), 8'h06, 4'd3, 1'b0, 1'b0);
        end
        sr_bits = 8'b1011_0000;
        done_pulses = 0;
        done_at     = -1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(1'b0, 1'b1, 2'b10, 1'b0, sr_bits[7-i], 8'h00);
            else       drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
            step();
            if (bus.done === 1'b1) begin
                done_pulses++;
                done_at = i;
            end
        end
        check("resume done pulses", 32'(done_pulses), 32'd1);
        check("resume done edge", 32'(done_at), 32'd4);
        check_all("resume end", 8'hD6, 4'd8, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
